rr_mux2_arbiter: RTL and testbench
==================================

# rr_mux2_arbiter

Two-input stream arbiter that drives a 2:1 data mux from a registered round-robin select. It sits directly upstream of a consumer that takes one data word per transfer: two producers offer words over valid/ready handshakes, the arbiter picks one per cycle, and it registers the chosen word together with the select that chose it. The block turns the purely combinational select/in0/in1 mux into a flow-controlled, fair, single-register stage.

## Interface
- WIDTH, 8, data width of each input and the output word

- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- in0_data  input  WIDTH  channel 0 word
- in0_valid  input  1  channel 0 word present
- in0_ready  output  1  channel 0 word accepted this cycle when high together with in0_valid
- in1_data  input  WIDTH  channel 1 word
- in1_valid  input  1  channel 1 word present
- in1_ready  output  1  channel 1 word accepted this cycle when high together with in1_valid
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream accepts out_data this cycle
- out_sel  output  1  registered select: channel index (0/1) the current out_data came from
- last_grant  output  1  round-robin pointer: index of the most recently granted channel

## Operation
- load = !out_valid || out_ready. Load is combinational and means the output register is free or is emptying this cycle.
- grant (combinational):
  - only in0_valid -> 0
  - only in1_valid -> 1
  - both valid -> !last_grant
  - neither valid -> no grant
- in0_ready = load && grant==0 && in0_valid. in1_ready = load && grant==1 && in1_valid. At most one ready is high per cycle.
- On a clock edge with load high and a grant:
  - out_data <= data of the granted channel
  - out_sel <= grant
  - out_valid <= 1
  - last_grant <= grant
- On a clock edge with load high and no grant: out_valid <= 0. out_data and out_sel hold their values, and last_grant holds.
- On a clock edge with load low (out_valid=1, out_ready=0), everything holds. The held word stays stable until it is consumed.
- Pointer: last_grant changes only on an accepted transfer. It never changes on idle cycles or stall cycles.
- Ready does not depend on the other channel's data. Ready does depend on both valids, through grant.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - out_valid=0, out_data=0, out_sel=0, last_grant=1
  - in0_ready and in1_ready are forced to 0 during reset
  - last_grant=1 means channel 0 wins the first tie.
- Latency: a word accepted on edge N appears with out_valid=1 after edge N, one cycle.
- Throughput: one word per cycle when out_ready stays high.
- Both channels continuously valid with out_ready=1: grants alternate 0,1,0,1 on successive cycles.
- Simultaneous consume and load: when out_ready=1 and out_valid=1 in the same cycle as a grant, the new word replaces the old one on the same edge. There is no bubble.
- Deassertion of rst_n is sampled on the next clk edge. No transfer is accepted in the cycle rst_n rises if it rises after that cycle's edge.
- Reset mid-operation: the held word is discarded and out_valid drops immediately, without waiting for clk. The pointer returns to 1.

## Test plan
- Reset check: hold rst_n=0 with all inputs toggling.
  - Required: out_valid=0, out_sel=0, last_grant=1, in0_ready=in1_ready=0 throughout.
- Single channel stream: in0_valid=1, in0_data=0x11,0x22,0x33, in1_valid=0, out_ready=1.
  - Required: out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after acceptance, out_sel=0 throughout.
- Fair tie: both valid continuously, in0_data=0xA0 and in1_data=0xB0, out_ready=1 for 6 cycles.
  - Required: out_sel sequence 0,1,0,1,0,1 and out_data alternating 0xA0/0xB0.
- Backpressure: fill with 0x5A, then out_ready=0 for 4 cycles with both inputs valid.
  - Required: out_data stays 0x5A, out_valid=1, both ready=0, last_grant frozen.
  - Then out_ready=1: the next word loads on the same edge with no bubble.
- Pointer memory: run in1-only traffic for 3 words, then assert both valid.
  - Required: the first tie grants channel 0 (last_grant was 1).
- Reset mid-transfer: with out_valid=1 holding 0xC3 and out_ready=0, pulse rst_n low between clock edges.
  - Required: out_valid=0 immediately, out_data=0, last_grant=1.
  - After release, the first tie grants channel 0.

Source files
------------

// File: rtl/rr_mux2_arbiter.sv
// Two-input valid/ready arbiter with round-robin fairness feeding a single
// registered output stage; the select that chose each word travels with it.
module rr_mux2_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel,
    output logic             last_grant
);

    logic load;
    logic have_grant;
    logic grant;

    // On a tie the channel that did not win last time goes first.
    always_comb begin
        have_grant = in0_valid || in1_valid;
        grant      = 1'b0;
        if (in0_valid && in1_valid) begin
            grant = ~last_grant;
        end else if (in1_valid) begin
            grant = 1'b1;
        end
    end

    assign load = !out_valid || out_ready;

    // Readies are gated by rst_n so no producer sees an accept while in reset.
    assign in0_ready = rst_n && load && have_grant && !grant && in0_valid;
    assign in1_ready = rst_n && load && have_grant &&  grant && in1_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the data register is reset because a cleared word is
    // part of the block's visible reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sel    <= 1'b0;
            last_grant <= 1'b1;
        end else if (load) begin
            if (have_grant) begin
                out_data   <= grant ? in1_data : in0_data;
                out_sel    <= grant;
                out_valid  <= 1'b1;
                last_grant <= grant;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Self-checking bench for rr_mux2_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model of the arbiter.
module tb_rr_mux2_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in0_data, in1_data, out_data;
    logic             in0_valid, in1_valid, in0_ready, in1_ready;
    logic             out_valid, out_ready, out_sel, last_grant;

    int checks = 0;
    int errors = 0;

    // Reference model state: the word the consumer currently sees and the
    // channel that was served most recently.
    bit             m_valid;
    logic [WIDTH-1:0] m_data;
    bit             m_sel;
    bit             m_ptr;

    bit   exp_r0, exp_r1;
    logic got_r0, got_r1;

    rr_mux2_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_data   (in0_data),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in1_data   (in1_data),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 1'b0;
        m_ptr   = 1'b1;
    endtask

    // Drives one cycle of inputs, samples the readies mid-cycle, lets one
    // rising edge pass and advances the model. Entered and left just after
    // a rising edge.
    task automatic step(input bit v0, input logic [WIDTH-1:0] d0,
                        input bit v1, input logic [WIDTH-1:0] d1,
                        input bit ordy);
        bit free;
        int winner;
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
        #1;
        got_r0 = in0_ready;
        got_r1 = in1_ready;
        free   = !m_valid || ordy;
        if (v0 && v1)  winner = m_ptr ? 0 : 1;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
        else           winner = -1;
        exp_r0 = free && (winner == 0);
        exp_r1 = free && (winner == 1);
        @(posedge clk);
        if (free) begin
            if (winner >= 0) begin
                m_valid = 1'b1;
                m_data  = (winner == 0) ? d0 : d1;
                m_sel   = (winner == 1);
                m_ptr   = (winner == 1);
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in0_valid = 1'($urandom);
            in1_valid = 1'($urandom);
            in0_data  = 8'($urandom);
            in1_data  = 8'($urandom);
            out_ready = 1'($urandom);
            #1;
            checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
            checks++; if (out_sel !== 1'b0)    begin errors++; $display("FAIL reset_out_sel got=%b exp=0", out_sel); end
            checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got=%b exp=1", last_grant); end
            checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
            checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready got=%b%b exp=00", in0_ready, in1_ready);
            end
        end
        @(negedge clk);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fair_tie();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
            checks++; if (out_sel !== 1'(i % 2)) begin errors++; $display("FAIL tie_sel[%0d] got=%b exp=%0d", i, out_sel, i % 2); end
            checks++; if (out_data !== ((i % 2) ? 8'hB0 : 8'hA0)) begin
                errors++; $display("FAIL tie_data[%0d] got=%h", i, out_data);
            end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_valid[%0d] got=%b exp=1", i, out_valid); end
        end
    endtask

    task automatic test_single_stream();
        logic [WIDTH-1:0] words [3];
        words = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, words[i], 1'b0, 8'hEE, 1'b1);
            checks++; if (got_r0 !== 1'b1 || got_r1 !== 1'b0) begin
                errors++; $display("FAIL stream_ready[%0d] got=%b%b exp=10", i, got_r0, got_r1);
            end
            checks++; if (out_data !== words[i] || out_sel !== 1'b0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_out[%0d] got=%h/%b/%b exp=%h/0/1", i, out_data, out_sel, out_valid, words[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL bp_fill got=%h exp=5a", out_data); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
            checks++; if (got_r0 !== 1'b0 || got_r1 !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, got_r0, got_r1);
            end
            checks++; if (out_data !== 8'h5A || out_valid !== 1'b1 || last_grant !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got=%h/%b/%b exp=5a/1/0", i, out_data, out_valid, last_grant);
            end
        end
        // Pointer is 0 after the in0 fill, so the tie goes to channel 1.
        step(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
        checks++; if (got_r1 !== 1'b1 || got_r0 !== 1'b0) begin
            errors++; $display("FAIL bp_release_ready got=%b%b exp=01", got_r0, got_r1);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h77 || out_sel !== 1'b1) begin
            errors++; $display("FAIL bp_release_out got=%b/%h/%b exp=1/77/1", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_pointer_memory();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(8'h90 + i), 1'b1);
            checks++; if (out_data !== 8'(8'h90 + i) || out_sel !== 1'b1) begin
                errors++; $display("FAIL ptr_in1[%0d] got=%h/%b", i, out_data, out_sel);
            end
        end
        step(1'b1, 8'hD0, 1'b1, 8'hD1, 1'b1);
        checks++; if (got_r0 !== 1'b1 || out_sel !== 1'b0 || out_data !== 8'hD0) begin
            errors++; $display("FAIL ptr_first_tie got=%b/%b/%h exp=1/0/d0", got_r0, out_sel, out_data);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h12, 1'b0);
        checks++; if (out_data !== 8'hC3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_hold got=%h/%b exp=c3/1", out_data, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || last_grant !== 1'b1) begin
            errors++; $display("FAIL mid_async got=%b/%h/%b exp=0/00/1", out_valid, out_data, last_grant);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        #1;
        step(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        checks++; if (out_sel !== 1'b0 || out_data !== 8'h44) begin
            errors++; $display("FAIL mid_first_tie got=%b/%h exp=0/44", out_sel, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            checks++; if (got_r0 !== exp_r0 || got_r1 !== exp_r1) begin
                errors++; $display("FAIL rand_ready[%0d] got=%b%b exp=%b%b", i, got_r0, got_r1, exp_r0, exp_r1);
            end
            checks++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== m_sel || last_grant !== m_ptr) begin
                errors++; $display("FAIL rand_out[%0d] got=%b/%h/%b/%b exp=%b/%h/%b/%b", i,
                                   out_valid, out_data, out_sel, last_grant, m_valid, m_data, m_sel, m_ptr);
            end
        end
    endtask

    initial begin
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_fair_tie();
        test_single_stream();
        test_backpressure();
        test_pointer_memory();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
